data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words stored (power of two, 2..65536).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the clock edges from request acceptance to response valid (1..15).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port req_valid  input  1  initiator presents a request.
REQ-006 Port req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port req_we  input  1  1 = store word, 0 = load word.
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_wdata  input  32  store data.
REQ-010 Port resp_valid  output  1  response available.
REQ-011 Port resp_ready  input  1  initiator takes the response this cycle.
REQ-012 Port resp_rdata  output  32  load data; 0 for stores and for errors.
REQ-013 Port resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP, with req_ready = 1 only in IDLE and resp_valid = 1 only in RESP.
REQ-015 Acceptance SHALL occur on an edge with state IDLE and req_valid = 1; at that edge the block SHALL latch req_we, req_addr and req_wdata and load the latency counter with LATENCY-1.
REQ-016 Request inputs SHALL be ignored outside the acceptance edge, and later changes to them SHALL NOT affect an in-flight request.
REQ-017 With LATENCY = 1 the block SHALL go IDLE->RESP at acceptance; otherwise it SHALL go IDLE->WAIT.
REQ-018 In WAIT the counter SHALL decrement each edge, and the edge on which it is 1 SHALL move to RESP, so resp_valid first rises exactly LATENCY edges after acceptance.
REQ-019 The word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-020 The error condition SHALL be req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH.
REQ-021 On the edge entering RESP, a store without error SHALL write the word, and a load without error SHALL capture the word into resp_rdata.
REQ-022 On the edge entering RESP, an erroneous request SHALL set resp_err = 1 and resp_rdata = 0, with no memory write.
REQ-023 A store SHALL return resp_rdata = 0.
REQ-024 resp_rdata and resp_err SHALL be registered and stable for the whole RESP state.
REQ-025 In RESP, an edge with resp_ready = 1 SHALL return the FSM to IDLE and clear resp_err and resp_rdata; with resp_ready = 0 the FSM SHALL stay in RESP indefinitely.
REQ-026 There SHALL be no same-cycle turnaround: a new request is accepted no earlier than the cycle after the response handshake, so the minimum request spacing is LATENCY+1 cycles.
REQ-027 A load issued after a completed store to the same word SHALL return the stored data.
REQ-028 resp_ready while not in RESP and req_valid while not in IDLE SHALL have no effect.
REQ-029 Memory contents SHALL be undefined at power-up and SHALL NOT be cleared by reset.

Reset
REQ-030 An edge with rst = 1 SHALL force state IDLE, counter 0, req_ready = 1 on the following cycle, resp_valid = 0, resp_rdata = 0 and resp_err = 0.
REQ-031 rst SHALL take priority over every other input on the same edge.
REQ-032 Reset during WAIT SHALL abandon the request with no memory write, and the abandoned request SHALL never produce a response.
REQ-033 Reset during RESP SHALL drop the response; a store already committed at RESP entry SHALL remain written.

Verification
REQ-034 Store then load: store 0xDEADBEEF to addr 0x10, handshake, then load addr 0x10 -> resp_valid exactly 2 edges after each acceptance; load returns 0xDEADBEEF with resp_err = 0.
REQ-035 Backpressure: load with resp_ready held 0 for 5 cycles -> resp_valid, resp_rdata and resp_err held constant; req_ready = 0 throughout; IDLE on the edge resp_ready = 1.
REQ-036 Errors: store to 0x12, and store to 0x400 with DEPTH = 256 -> resp_err = 1 and resp_rdata = 0; a following load of word 0x100>>2 returns its prior contents unchanged.
REQ-037 Reset mid-WAIT: with LATENCY = 4, accept a store of 0x1234 to 0x20 and assert rst 2 edges later -> no resp_valid; a subsequent load of 0x20 returns the old value.
REQ-038 Input isolation: change req_addr and req_wdata every cycle after acceptance -> response reflects only the values latched at acceptance; with LATENCY = 1, resp_valid rises on the edge after acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Single-outstanding word memory responder. Accepts one
//               load/store request at a time, presents the response a fixed
//               LATENCY clock edges after acceptance and holds it until the
//               initiator takes it. Misaligned or out-of-range byte
//               addresses complete with resp_err = 1 and never touch the
//               memory array.
//
// Parameters  : DEPTH      number of 32-bit words (power of two, 2..65536)
//               LATENCY    edges from acceptance to resp_valid (1..15)
//
// Ports       : clk         single clock, rising edge
//               rst         synchronous active-high reset
//               req_valid   request present           (in)
//               req_ready   request accepted this cycle (out, IDLE only)
//               req_we      1 = store, 0 = load       (in)
//               req_addr    byte address              (in, 32)
//               req_wdata   store data                (in, 32)
//               resp_valid  response present          (out, RESP only)
//               resp_ready  initiator takes response  (in)
//               resp_rdata  load data, 0 for stores/errors (out, 32)
//               resp_err    misaligned / out of range (out)
//
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          c_AW          = $clog2(DEPTH);
    localparam logic [29:0] c_DEPTH_WORDS = 30'(DEPTH);
    localparam logic [3:0]  c_CNT_LOAD    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state_q, w_state_d;
    logic [3:0]      r_cnt_q,   w_cnt_d;
    logic            r_we_q,    w_we_d;
    logic [31:0]     r_addr_q,  w_addr_d;
    logic [31:0]     r_wdata_q, w_wdata_d;
    logic [31:0]     r_rdata_q, w_rdata_d;
    logic            r_err_q,   w_err_d;

    // Contents are deliberately left out of reset.
    logic [31:0]     r_mem [DEPTH];

    logic            w_enter_resp;
    logic            w_op_we;
    logic [31:0]     w_op_addr;
    logic [31:0]     w_op_wdata;
    logic            w_op_err;
    logic [c_AW-1:0] w_op_idx;
    logic            w_mem_we;

    // The operation committed on RESP entry. With LATENCY = 1 the RESP entry
    // coincides with acceptance, so the live request inputs are used; in
    // every other case the values latched at acceptance are used.
    always_comb begin
        if (r_state_q == S_IDLE) begin
            w_op_we    = req_we;
            w_op_addr  = req_addr;
            w_op_wdata = req_wdata;
        end else begin
            w_op_we    = r_we_q;
            w_op_addr  = r_addr_q;
            w_op_wdata = r_wdata_q;
        end
    end

    assign w_op_err = (w_op_addr[1:0] != 2'b00) || (w_op_addr[31:2] >= c_DEPTH_WORDS);
    assign w_op_idx = w_op_addr[c_AW+1:2];
    assign w_mem_we = w_enter_resp && w_op_we && !w_op_err;

    // Next-state and datapath
    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_we_d       = r_we_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_rdata_d    = r_rdata_q;
        w_err_d      = r_err_q;
        w_enter_resp = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (req_valid) begin
                    w_we_d    = req_we;
                    w_addr_d  = req_addr;
                    w_wdata_d = req_wdata;
                    w_cnt_d   = c_CNT_LOAD;
                    if (LATENCY == 1) begin
                        w_state_d    = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_d = r_cnt_q - 4'd1;
                if (r_cnt_q == 4'd1) begin
                    w_state_d    = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_d = S_IDLE;
                    w_rdata_d = 32'd0;
                    w_err_d   = 1'b0;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Response payload is captured once, on the edge entering RESP, and
        // then held unchanged until the handshake.
        if (w_enter_resp) begin
            w_err_d = w_op_err;
            if (w_op_we || w_op_err) begin
                w_rdata_d = 32'd0;
            end else begin
                w_rdata_d = r_mem[w_op_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= 4'd0;
            r_we_q    <= 1'b0;
            r_addr_q  <= 32'd0;
            r_wdata_q <= 32'd0;
            r_rdata_q <= 32'd0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_we_q    <= w_we_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_rdata_q <= w_rdata_d;
            r_err_q   <= w_err_d;
        end
    end

    // Reset suppresses a commit on the same edge; earlier commits persist.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_op_idx] <= w_op_wdata;
        end
    end

    assign req_ready  = (r_state_q == S_IDLE);
    assign resp_valid = (r_state_q == S_RESP);
    assign resp_rdata = r_rdata_q;
    assign resp_err   = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. Three instances
//               with different DEPTH/LATENCY share one clock and reset; a
//               word-array reference model predicts every response.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int N = 3;

    function automatic int dep(int i);
        case (i)
            0:       return 256;
            1:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int lat(int i);
        case (i)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_we;
    logic [N-1:0]  resp_ready;
    logic [31:0]   req_addr  [N];
    logic [31:0]   req_wdata [N];
    logic [N-1:0]  req_ready;
    logic [N-1:0]  resp_valid;
    logic [N-1:0]  resp_err;
    logic [31:0]   resp_rdata [N];

    logic [31:0]   mdl [N][256];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.DEPTH(16), .LATENCY(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(1)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_err(int i, logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(dep(i)));
    endfunction

    // Full transaction: present, wait LATENCY edges while scrambling every
    // request input, hold the response for 'hold' cycles, then handshake.
    task automatic txn(int i, bit we, logic [31:0] addr, logic [31:0] wdata, int hold);
        int          L;
        bit          e;
        logic [31:0] exp_rd;
        L      = lat(i);
        e      = addr_err(i, addr);
        exp_rd = 32'd0;
        if (!e) begin
            if (we) mdl[i][int'(addr >> 2)] = wdata;
            else    exp_rd = mdl[i][int'(addr >> 2)];
        end

        @(negedge clk);
        chk($sformatf("i%0d req_ready before request", i), 32'(req_ready[i]), 32'd1);
        req_valid[i]  = 1'b1;
        req_we[i]     = we;
        req_addr[i]   = addr;
        req_wdata[i]  = wdata;
        resp_ready[i] = 1'b0;

        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            req_valid[i] = 1'($urandom);
            req_we[i]    = 1'($urandom);
            req_addr[i]  = $urandom;
            req_wdata[i] = $urandom;
            if (k < L) begin
                chk($sformatf("i%0d resp_valid early k=%0d", i, k), 32'(resp_valid[i]), 32'd0);
                chk($sformatf("i%0d req_ready busy k=%0d", i, k), 32'(req_ready[i]), 32'd0);
                resp_ready[i] = 1'($urandom);
            end
        end
        chk($sformatf("i%0d resp_valid at latency", i), 32'(resp_valid[i]), 32'd1);
        chk($sformatf("i%0d req_ready in resp", i), 32'(req_ready[i]), 32'd0);
        chk($sformatf("i%0d resp_rdata addr=%h we=%0d", i, addr, we), resp_rdata[i], exp_rd);
        chk($sformatf("i%0d resp_err addr=%h", i, addr), 32'(resp_err[i]), 32'(e));
        resp_ready[i] = (hold == 0);

        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            req_valid[i] = 1'($urandom);
            req_addr[i]  = $urandom;
            chk($sformatf("i%0d hold resp_valid h=%0d", i, h), 32'(resp_valid[i]), 32'd1);
            chk($sformatf("i%0d hold req_ready h=%0d", i, h), 32'(req_ready[i]), 32'd0);
            chk($sformatf("i%0d hold resp_rdata h=%0d", i, h), resp_rdata[i], exp_rd);
            chk($sformatf("i%0d hold resp_err h=%0d", i, h), 32'(resp_err[i]), 32'(e));
            if (h == hold) resp_ready[i] = 1'b1;
        end

        @(negedge clk);
        resp_ready[i] = 1'b0;
        req_valid[i]  = 1'b0;
        chk($sformatf("i%0d resp_valid after handshake", i), 32'(resp_valid[i]), 32'd0);
        chk($sformatf("i%0d req_ready after handshake", i), 32'(req_ready[i]), 32'd1);
        chk($sformatf("i%0d resp_rdata cleared", i), resp_rdata[i], 32'd0);
        chk($sformatf("i%0d resp_err cleared", i), 32'(resp_err[i]), 32'd0);
    endtask

    task automatic chk_idle(int i, string tag);
        chk($sformatf("i%0d %s req_ready", i, tag), 32'(req_ready[i]), 32'd1);
        chk($sformatf("i%0d %s resp_valid", i, tag), 32'(resp_valid[i]), 32'd0);
        chk($sformatf("i%0d %s resp_rdata", i, tag), resp_rdata[i], 32'd0);
        chk($sformatf("i%0d %s resp_err", i, tag), 32'(resp_err[i]), 32'd0);
    endtask

    initial begin
        int          D;
        int          sel;
        logic [31:0] a;
        logic [31:0] v;

        rst        = 1'b1;
        req_valid  = '0;
        req_we     = '0;
        resp_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) chk_idle(i, "after reset");

        // Give every word a known value so all later loads are predictable.
        for (int i = 0; i < N; i++)
            for (int w = 0; w < dep(i); w++)
                txn(i, 1'b1, 32'(w) << 2, $urandom, 0);

        // Store then load at the default latency.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 0);

        // Backpressure for five cycles.
        txn(0, 1'b0, 32'h10, 32'h0, 5);

        // Misaligned and out-of-range stores must not disturb memory
        // (0x400 would alias word 0 if range were ignored).
        txn(0, 1'b1, 32'h12, 32'h11111111, 1);
        txn(0, 1'b1, 32'h400, 32'h22222222, 0);
        txn(0, 1'b0, 32'h100, 32'h0, 0);
        txn(0, 1'b0, 32'h0, 32'h0, 0);
        txn(0, 1'b0, 32'h3FC, 32'h0, 0);
        txn(0, 1'b0, 32'h3FF, 32'h0, 0);

        // Reset mid-WAIT on the LATENCY = 4 instance; rst also collides with
        // a fresh req_valid and must win.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1;
        req_addr[1]  = 32'h20; req_wdata[1] = 32'h1234;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_valid[1] = 1'b1; req_addr[1] = 32'h24;
        @(negedge clk);
        rst = 1'b0;
        req_valid[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk_idle(1, $sformatf("abandoned c=%0d", c));
            @(negedge clk);
        end
        txn(1, 1'b0, 32'h20, 32'h0, 0);
        txn(1, 1'b0, 32'h24, 32'h0, 0);

        // Reset while a store response is pending: data stays committed.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1;
        req_addr[0]  = 32'h44; req_wdata[0] = 32'hCAFEF00D;
        mdl[0][17]   = 32'hCAFEF00D;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("i0 resp_valid before resp reset", 32'(resp_valid[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle(0, "after resp reset");
        txn(0, 1'b0, 32'h44, 32'h0, 0);

        // Randomized traffic on every instance.
        for (int i = 0; i < N; i++) begin
            D = dep(i);
            for (int t = 0; t < 40; t++) begin
                sel = int'($urandom_range(0, 9));
                a   = 32'($urandom_range(0, D - 1)) << 2;
                if (sel == 0)      a = a | 32'($urandom_range(1, 3));
                else if (sel == 1) a = (32'(D) + 32'($urandom_range(0, 1000))) << 2;
                else if (sel == 2) a = {$urandom} & 32'hFFFF_FFFC;
                v = $urandom;
                txn(i, 1'($urandom), a, v, int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
